// File: rtl/barrel_left_shift_seq.sv
// -----------------------------------------------------------------------------
// barrel_left_shift_seq
//
// Sequential logical left shifter. A 32-bit operand is shifted left by a 5-bit
// amount, one power-of-two stage per clock: stages of 16, 8, 4, 2 and 1 bit
// positions are applied in that order. Each stage is applied only when its bit
// of the captured amount is set. Vacated LSBs are zero-filled. Bits shifted
// past bit 31 are discarded.
//
// Parameters
//   ZERO_FAST : 1 -> a zero shift amount finishes one edge after acceptance.
//               0 -> a zero shift amount walks all five stages like any other.
//
// Ports
//   clk   in   1   sole clock, rising edge
//   rst   in   1   synchronous active-high reset
//   start in   1   request strobe, honoured only while idle
//   A     in  32   operand, captured on the accepting edge
//   shamt in   5   shift amount 0..31, captured on the accepting edge
//   out   out 32   registered result; changes only when a new result lands
//   busy  out  1   high while an operation is in flight (SHIFT or DONE)
//   done  out  1   one-cycle pulse: out has just been loaded with a new result
// -----------------------------------------------------------------------------
module barrel_left_shift_seq #(
    parameter int ZERO_FAST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] acc_r;
    logic [4:0]  shamt_r;
    logic [2:0]  k_r;
    logic [31:0] out_r;
    logic        done_r;
    logic        busy_r;

    logic [31:0] step_s;
    logic        zero_skip_s;
    logic        last_step_s;
    logic        load_s;
    logic [31:0] result_s;

    // One barrel stage: shift by 2^k when amount bit k is set, otherwise pass.
    function automatic logic [31:0] stage_shift(
        input logic [31:0] v,
        input logic [2:0]  k,
        input logic [4:0]  amt
    );
        logic [31:0] r;
        case (k)
            3'd4:    r = amt[4] ? {v[15:0], 16'h0000}  : v;
            3'd3:    r = amt[3] ? {v[23:0], 8'h00}     : v;
            3'd2:    r = amt[2] ? {v[27:0], 4'h0}      : v;
            3'd1:    r = amt[1] ? {v[29:0], 2'b00}     : v;
            3'd0:    r = amt[0] ? {v[30:0], 1'b0}      : v;
            default: r = v;
        endcase
        return r;
    endfunction

    // Stage datapath and completion decode shared by next-state and outputs.
    always_comb begin
        step_s      = stage_shift(acc_r, k_r, shamt_r);
        zero_skip_s = (ZERO_FAST != 0) && (shamt_r == 5'd0);
        // A zero amount on the fast path finishes on the first SHIFT edge,
        // which is indistinguishable from never entering the stage walk.
        last_step_s = (k_r == 3'd0) || zero_skip_s;
    end

    // State register, plus busy registered from the state being entered so
    // it always equals "state is not IDLE".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: when to load the result register and with what.
    always_comb begin
        load_s   = 1'b0;
        result_s = acc_r;
        case (state_r)
            ST_SHIFT: begin
                load_s = last_step_s;
                if (zero_skip_s) begin
                    result_s = acc_r;
                end else begin
                    result_s = step_s;
                end
            end
            ST_IDLE: begin
                load_s = 1'b0;
            end
            ST_DONE: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Operand capture, stage walk, and registered result/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= 32'h0000_0000;
            shamt_r <= 5'd0;
            k_r     <= 3'd4;
            out_r   <= 32'h0000_0000;
            done_r  <= 1'b0;
        end else begin
            // done is high only on the cycle after the load edge.
            done_r <= load_s;
            if (load_s) begin
                out_r <= result_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r   <= A;
                        shamt_r <= shamt;
                        k_r     <= 3'd4;
                    end
                end
                ST_SHIFT: begin
                    acc_r <= step_s;
                    if (last_step_s) begin
                        k_r <= 3'd4;
                    end else begin
                        k_r <= k_r - 3'd1;
                    end
                end
                ST_DONE: begin
                    k_r <= 3'd4;
                end
                default: begin
                    k_r <= 3'd4;
                end
            endcase
        end
    end

    assign out  = out_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule
